segre_ic_refill: RTL and testbench
==================================

Name: segre_ic_refill

Overview:
- Instruction-cache refill engine that sits directly upstream of the fetch stage.
- Consumes the fetch stage's miss/address/access outputs and fetches the missing lane from memory one word per beat.
- Returns the assembled lane to the instruction cache in a one-cycle write pulse, together with the index of the line to replace.
- Selects the victim line with a round-robin replacement pointer.

Parameters:
ADDR_SIZE, 32, byte address width
WORD_SIZE, 32, memory beat width in bits
ICACHE_LANE_SIZE, 128, lane width in bits; must be a multiple of WORD_SIZE
ICACHE_INDEX_SIZE, 2, index width (ICACHE_LINES = 2**ICACHE_INDEX_SIZE)
Derived: BEATS = ICACHE_LANE_SIZE/WORD_SIZE; LANE_BYTES = ICACHE_LANE_SIZE/8

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
ic_miss_i  in  1  icache tag miss from fetch stage
ic_addr_i  in  ADDR_SIZE  fetch PC
ic_access_i  in  1  fetch stage is accessing the icache this cycle
mmu_data_o  out  1  one-cycle pulse: lane write into icache tag+data
mmu_wr_data_o  out  ICACHE_LANE_SIZE  refilled lane
mmu_lru_index_o  out  ICACHE_INDEX_SIZE  line to be replaced
mem_rd_req_o  out  1  memory read request
mem_addr_o  out  ADDR_SIZE  word address of current beat
mem_gnt_i  in  1  memory accepted request this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  WORD_SIZE  read data
busy_o  out  1  refill in progress (state != IDLE)

Behaviour:
- Reset (rst_i=1 at a clock edge, in any state including mid-refill):
  - state=IDLE, beat counter=0, victim pointer=0, lane buffer=0, guard=0.
  - All outputs 0 on the following cycle.
  - A memory response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If ic_miss_i & ic_access_i & !guard: latch base = ic_addr_i with the low log2(LANE_BYTES) bits cleared, set beat=0, go to REQ.
  - mem_rvalid_i is ignored in IDLE.
- REQ:
  - mem_rd_req_o=1, mem_addr_o = base + 4*beat.
  - Request and address stay stable until mem_gnt_i=1; then go to WAIT.
  - mem_rvalid_i is ignored in REQ (data arrives no earlier than the cycle after grant).
- WAIT:
  - mem_rd_req_o=0.
  - On mem_rvalid_i, write mem_rdata_i into lane bits [beat*WORD_SIZE +: WORD_SIZE] (word 0 at LSBs).
  - If beat==BEATS-1 go to DONE; otherwise beat++ and go to REQ.
- DONE (exactly one cycle):
  - mmu_data_o=1, mmu_wr_data_o = assembled lane, mmu_lru_index_o = victim pointer.
  - Victim pointer increments modulo ICACHE_LINES, wrapping from ICACHE_LINES-1 to 0.
  - Next state is IDLE with guard=1.
- Guard:
  - Suppresses ic_miss_i for exactly the first IDLE cycle after DONE, while the fetch stage re-probes the newly written tag.
  - Cleared on the next clock.
- Output hold:
  - mmu_wr_data_o and mmu_lru_index_o are meaningful only while mmu_data_o=1.
  - Outside DONE they hold their last values (0 after reset).
  - mem_addr_o holds the last beat address outside REQ.
- No other input affects an in-flight refill.
  - ic_miss_i and ic_addr_i changes during REQ/WAIT/DONE are ignored; the latched base is used.
  - A second miss is served only after returning to IDLE.
- Latency with zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): miss sampled at cycle T, mmu_data_o=1 at cycle T+1+2*BEATS (T+9 with defaults).
- Memory stall: each extra cycle of gnt or rvalid delay adds exactly one cycle.
- busy_o is combinational from state.

Test Plan:
- Reset, then miss at ic_addr_i=0x0000_1234 with zero-wait memory returning 0x11,0x22,0x33,0x44 -> requests in order to 0x1230, 0x1234, 0x1238, 0x123C; mmu_data_o high exactly at T+9 for one cycle; mmu_wr_data_o=0x00000044_00000033_00000022_00000011; mmu_lru_index_o=0.
- Five back-to-back misses -> mmu_lru_index_o sequence 0,1,2,3,0 (wrap); the miss held high in the cycle right after each DONE does not start a new refill.
- mem_gnt_i withheld 3 cycles on beat 2 -> mem_rd_req_o and mem_addr_o=base+8 stable throughout; mmu_data_o delayed by exactly 3 cycles; lane contents correct.
- ic_addr_i changed to 0x8000 during WAIT -> remaining beats still use the original base; ic_miss_i=1 with ic_access_i=0 in IDLE -> no request.
- rst_i asserted in WAIT of beat 1, with mem_rvalid_i=1 arriving the next cycle -> all outputs 0, victim pointer 0, no mmu_data_o pulse; a subsequent miss refills correctly using index 0.
- mem_rvalid_i pulsed spuriously in IDLE and REQ -> lane buffer unchanged, no state change.

Source files
------------

// File: rtl/segre_ic_refill.sv
// segre_ic_refill: instruction-cache lane refill engine with round-robin victim selection
module segre_ic_refill #(
  parameter int ADDR_SIZE         = 32,
  parameter int WORD_SIZE         = 32,
  parameter int ICACHE_LANE_SIZE  = 128,
  parameter int ICACHE_INDEX_SIZE = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  input  logic                         ic_access_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_rd_req_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [WORD_SIZE-1:0]         mem_rdata_i,
  output logic                         busy_o
);
  localparam int BEATS      = ICACHE_LANE_SIZE / WORD_SIZE;
  localparam int LANE_BYTES = ICACHE_LANE_SIZE / 8;
  localparam int BW         = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t                       state_q, state_d;
  logic [BW-1:0]                beat_q, beat_d;
  logic [ICACHE_INDEX_SIZE-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [ICACHE_LANE_SIZE-1:0]  lane_q, lane_d, wr_q, wr_d;
  logic [ADDR_SIZE-1:0]         addr_q, addr_d;
  logic                         guard_q, guard_d;
  // The lane and victim index are shown live during DONE and held from registered copies otherwise
  assign busy_o          = state_q != IDLE;
  assign mem_rd_req_o    = state_q == REQ;
  assign mem_addr_o      = addr_q;
  assign mmu_data_o      = state_q == DONE;
  assign mmu_wr_data_o   = mmu_data_o ? lane_q : wr_q;
  assign mmu_lru_index_o = mmu_data_o ? ptr_q : idx_q;
  // Next-state: addr_q tracks the current beat address so it also holds the last one outside REQ
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    guard_d = state_q == DONE;
    case (state_q)
      IDLE: if (ic_miss_i && ic_access_i && !guard_q) begin
        state_d = REQ;
        beat_d  = '0;
        addr_d  = ic_addr_i & ~ADDR_SIZE'(LANE_BYTES - 1);
      end
      REQ: state_d = mem_gnt_i ? WAIT : REQ;
      WAIT: if (mem_rvalid_i) begin
        lane_d[beat_q*WORD_SIZE +: WORD_SIZE] = mem_rdata_i;
        if (beat_q == BW'(BEATS - 1)) state_d = DONE;
        else begin
          state_d = REQ;
          beat_d  = beat_q + 1'b1;
          addr_d  = addr_q + ADDR_SIZE'(WORD_SIZE / 8);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ptr_q + 1'b1;
        idx_d   = ptr_q;
        wr_d    = lane_q;
      end
    endcase
  end
  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      guard_q <= guard_d;
    end
  end
endmodule

// File: tb/tb_segre_ic_refill.sv
// tb_segre_ic_refill: directed and randomized refill sequences checked against a lane-level model
module tb_segre_ic_refill;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ic_miss = 1'b0, ic_access = 1'b0;
  logic [31:0]  ic_addr = '0;
  logic         mmu_data;
  logic [127:0] mmu_wr_data;
  logic [1:0]   mmu_idx;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         busy;
  int           nv = 0, err = 0;
  logic [1:0]   exp_idx = '0;
  segre_ic_refill dut (
    .clk_i(clk), .rst_i(rst), .ic_miss_i(ic_miss), .ic_addr_i(ic_addr), .ic_access_i(ic_access),
    .mmu_data_o(mmu_data), .mmu_wr_data_o(mmu_wr_data), .mmu_lru_index_o(mmu_idx),
    .mem_rd_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nv++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic refill(input logic [31:0] a, input logic [3:0][31:0] w, input logic [3:0][3:0] gd, input logic [3:0][3:0] rd);
    logic [31:0]  base;
    logic [127:0] lane;
    base = a & ~32'hF;
    lane = '0;
    ic_miss = 1'b1; ic_access = 1'b1; ic_addr = a;
    step;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < int'(gd[b]); k++) begin
        chk("req_stall", {mem_req, busy, mmu_data}, 3'b110);
        chk("addr_stall", mem_addr, base + 32'(4 * b));
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        ic_addr = $urandom; ic_miss = 1'($urandom);
        step;
      end
      chk("req", {mem_req, busy, mmu_data}, 3'b110);
      chk("addr", mem_addr, base + 32'(4 * b));
      mem_gnt = 1'b1; mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      step;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int k = 0; k < int'(rd[b]); k++) begin
        chk("wait_stall", {mem_req, busy, mmu_data}, 3'b010);
        ic_addr = 32'h8000;
        step;
      end
      chk("wait", {mem_req, busy, mmu_data}, 3'b010);
      ic_addr = 32'h8000;
      mem_rvalid = 1'b1; mem_rdata = w[b];
      step;
      mem_rvalid = 1'b0;
      lane = lane | ({96'b0, w[b]} << (32 * b));
    end
    chk("done_flags", {mmu_data, busy, mem_req}, 3'b110);
    chk("done_lane", mmu_wr_data, lane);
    chk("done_idx", mmu_idx, exp_idx);
    chk("done_addr", mem_addr, base + 32'd12);
    ic_miss = 1'b1; ic_access = 1'b1; ic_addr = a;
    step;
    chk("guard_flags", {mmu_data, busy, mem_req}, 3'b000);
    chk("hold_lane", mmu_wr_data, lane);
    chk("hold_idx", mmu_idx, exp_idx);
    step;
    chk("guard_nostart", {busy, mem_req}, 2'b00);
    ic_miss = 1'b0;
    exp_idx = exp_idx + 1'b1;
  endtask
  initial begin
    logic [3:0][31:0] w;
    step; step;
    rst = 1'b0;
    chk("rst_flags", {mmu_data, mem_req, busy}, 3'b000);
    chk("rst_lane", mmu_wr_data, '0);
    chk("rst_idx", mmu_idx, 2'd0);
    chk("rst_addr", mem_addr, '0);
    for (int i = 0; i < 5; i++) begin
      ic_miss = 1'b1; ic_access = 1'b0; ic_addr = $urandom;
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      step;
      chk("no_access", {busy, mem_req}, 2'b00);
    end
    ic_miss = 1'b0; mem_rvalid = 1'b0;
    refill(32'h0000_1234, {32'h44, 32'h33, 32'h22, 32'h11}, '0, '0);
    for (int i = 0; i < 4; i++) refill($urandom, {$urandom, $urandom, $urandom, $urandom}, '0, '0);
    refill($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h0300, '0);
    for (int i = 0; i < 6; i++)
      refill($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom) & 16'h3333, 16'($urandom) & 16'h3333);
    ic_miss = 1'b1; ic_access = 1'b1; ic_addr = $urandom;
    step;
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
    step;
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; ic_miss = 1'b0;
    chk("pre_rst_wait", {busy, mem_req}, 2'b10);
    rst = 1'b1;
    step;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    chk("mid_rst_flags", {mmu_data, mem_req, busy}, 3'b000);
    chk("mid_rst_lane", mmu_wr_data, '0);
    chk("mid_rst_idx", mmu_idx, 2'd0);
    chk("mid_rst_addr", mem_addr, '0);
    step;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_quiet", {mmu_data, busy}, 2'b00);
      step;
    end
    exp_idx = '0;
    w = {$urandom, $urandom, $urandom, $urandom};
    refill($urandom, w, '0, 16'h1021);
    refill($urandom, {$urandom, $urandom, $urandom, $urandom}, 16'h2103, '0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, err);
    $finish;
  end
endmodule
